fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// Fetch-stage program counter with branch-delay-slot redirects, a one-entry
// redirect buffer that holds a target across stalls, and address legality flags.
module fetch_pc #(
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        d_valid,
    input  logic [1:0]  br_type,
    input  logic        jump,
    input  logic [31:0] pc_D,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc_F,
    output logic        fetch_valid,
    output logic        addr_err,
    output logic        pend,
    output logic [15:0] redir_cnt
);

    localparam logic [1:0] BR_COND = 2'd0;
    localparam logic [1:0] BR_J    = 2'd1;
    localparam logic [1:0] BR_JR   = 2'd2;

    // One past the last legal word address, kept at 33 bits so the top of a
    // range ending at 2^32 does not wrap to zero.
    localparam logic [32:0] PC_LO = {1'b0, PC_INIT};
    localparam logic [32:0] PC_HI = {1'b0, PC_INIT} + 33'(4 * IM_WORDS);

    logic [31:0] buf_target;
    logic        redir_req;
    logic [31:0] target;
    logic [31:0] br_offset;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} >= PC_LO) && ({1'b0, a} < PC_HI);
    endfunction

    always_comb begin
        redir_req = d_valid && ((br_type == BR_J) || (br_type == BR_JR) ||
                                ((br_type == BR_COND) && jump));
    end

    always_comb begin
        br_offset = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        target    = '0;
        case (br_type)
            BR_COND: target = pc_D + 32'd4 + br_offset;
            BR_J:    target = {pc_D[31:28], imm26, 2'b00};
            BR_JR:   target = rs_val;
            default: target = '0;
        endcase
    end

    always_comb begin
        fetch_valid = addr_legal(pc_F);
    end

    // A live redirect always beats the buffered one; the buffer is simply
    // dropped because pend clears on any applied redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_F       <= PC_INIT;
            buf_target <= '0;
            pend       <= 1'b0;
            addr_err   <= 1'b0;
            redir_cnt  <= '0;
        end else if (stall_F) begin
            if (redir_req) begin
                buf_target <= target;
                pend       <= 1'b1;
            end
        end else if (redir_req) begin
            pc_F      <= target;
            pend      <= 1'b0;
            redir_cnt <= redir_cnt + 16'd1;
            if (!addr_legal(target)) begin
                addr_err <= 1'b1;
            end
        end else if (pend) begin
            pc_F      <= buf_target;
            pend      <= 1'b0;
            redir_cnt <= redir_cnt + 16'd1;
            if (!addr_legal(buf_target)) begin
                addr_err <= 1'b1;
            end
        end else begin
            // Running off the end of memory is not a redirect error.
            pc_F <= pc_F + 32'd4;
        end
    end

endmodule
